// File: rtl/alarm_bank.sv
// Multi-channel HH:MM alarm unit. Each channel edge-detects a match against the running
// clock time, rings for a bounded time, and supports snooze (with a retry limit) and dismiss.
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [15:0]         cur_time,
  input  logic                global_en,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [15:0]         wr_time,
  input  logic                wr_arm,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic                ring,
  output logic [IW-1:0]       active_idx,
  output logic                snoozed
);

  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  logic [N_ALARMS-1:0] ring_vec_d, ring_vec_q;
  logic [N_ALARMS-1:0] snoozed_vec_d;
  logic                ring_d, ring_q;
  logic [IW-1:0]       active_idx_d, active_idx_q;
  logic                snoozed_d, snoozed_q;

  for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
    logic [15:0]   alarm_time_d, alarm_time_q;
    logic          armed_d, armed_q;
    logic          prev_match_d, prev_match_q;
    state_t        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [SW-1:0] snz_d, snz_q;
    logic          match;
    logic          trigger;
    logic          wr_hit;

    assign match   = armed_q && (cur_time == alarm_time_q);
    assign trigger = match && !prev_match_q && global_en;
    // Out-of-range write indices simply match no channel.
    assign wr_hit  = wr_en && (wr_idx == IW'(gi));

    always_comb begin
      alarm_time_d = alarm_time_q;
      armed_d      = armed_q;
      prev_match_d = match;
      state_d      = state_q;
      cnt_d        = cnt_q;
      snz_d        = snz_q;

      // Seeding prev_match from the new settings keeps a write of the current minute silent.
      if (wr_hit) begin
        alarm_time_d = wr_time;
        armed_d      = wr_arm;
        prev_match_d = wr_arm && (cur_time == wr_time);
      end

      if (!global_en || wr_hit) begin
        state_d = IDLE;
        cnt_d   = '0;
        snz_d   = '0;
      end else if (dismiss && (state_q != IDLE)) begin
        state_d = IDLE;
        cnt_d   = '0;
        snz_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_d = '0;
            snz_d = '0;
            if (trigger) begin
              state_d = RINGING;
            end
          end
          RINGING: begin
            if (snooze) begin
              cnt_d = '0;
              if (snz_q < SW'(MAX_SNOOZE)) begin
                state_d = SNOOZED;
                snz_d   = snz_q + SW'(1);
              end else begin
                state_d = IDLE;
                snz_d   = '0;
              end
            end else if (sec_tick) begin
              if (cnt_q == CW'(RING_SECS - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                snz_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          SNOOZED: begin
            if (sec_tick) begin
              if (cnt_q == CW'(SNOOZE_SECS - 1)) begin
                state_d = RINGING;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            snz_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        alarm_time_q <= 16'h0000;
        armed_q      <= 1'b0;
        prev_match_q <= 1'b0;
        state_q      <= IDLE;
        cnt_q        <= '0;
        snz_q        <= '0;
      end else begin
        alarm_time_q <= alarm_time_d;
        armed_q      <= armed_d;
        prev_match_q <= prev_match_d;
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        snz_q        <= snz_d;
      end
    end

    // Outputs register the next state so a trigger shows up one edge after the match.
    assign ring_vec_d[gi]    = (state_d == RINGING);
    assign snoozed_vec_d[gi] = (state_d == SNOOZED);
  end

  always_comb begin
    active_idx_d = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec_d[i]) begin
        active_idx_d = IW'(i);
      end
    end
  end

  assign ring_d    = |ring_vec_d;
  assign snoozed_d = |snoozed_vec_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_vec_q   <= '0;
      ring_q       <= 1'b0;
      active_idx_q <= '0;
      snoozed_q    <= 1'b0;
    end else begin
      ring_vec_q   <= ring_vec_d;
      ring_q       <= ring_d;
      active_idx_q <= active_idx_d;
      snoozed_q    <= snoozed_d;
    end
  end

  assign ring_vec   = ring_vec_q;
  assign ring       = ring_q;
  assign active_idx = active_idx_q;
  assign snoozed    = snoozed_q;

endmodule
